// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite initiator.
// Also holds register offsets of the timer slave it usually drives.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    localparam logic [31:0] CONTROL   = 32'h0;
    localparam logic [31:0] PRESCALER = 32'h4;
    localparam logic [31:0] COUNTER   = 32'h8;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command at a time becomes AW/W/B or AR/R traffic.
// Results are parked on the rsp port until consumed; non-OKAY replies are counted.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                  axi_clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDDATA,
    output logic [DATA_W/8-1:0]   WDSTRB,
    output logic                  WDVALID,
    input  logic                  WDREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_live;
    logic                  r_write;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_rdata;
    logic [1:0]            r_resp;
    logic [ERR_CNT_W-1:0]  r_err;

    logic                  w_cmd_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_cap;
    logic [1:0]            w_resp;

    // r_live keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = r_live && (r_state == IDLE);
    assign AWVALID   = (r_state == WR_REQ) && !r_aw_done;
    assign WDVALID   = (r_state == WR_REQ) && !r_w_done;
    assign BREADY    = (r_state == WR_RESP);
    assign ARVALID   = (r_state == RD_REQ);
    assign RREADY    = (r_state == RD_DATA);
    assign rsp_valid = (r_state == RSP);

    assign AWADDR    = r_addr;
    assign ARADDR    = r_addr;
    assign WDDATA    = r_wdata;
    assign WDSTRB    = r_wstrb;
    assign rsp_write = r_write;
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign err_count = r_err;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WDVALID && WDREADY;
    assign w_b_hs   = BVALID && BREADY;
    assign w_ar_hs  = ARVALID && ARREADY;
    assign w_r_hs   = RVALID && RREADY;
    assign w_cap    = w_b_hs || w_r_hs;
    assign w_resp   = w_b_hs ? BRESP : RRESP;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_hs) w_next = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_next = WR_RESP;
            end
            WR_RESP: begin
                if (w_b_hs) w_next = RSP;
            end
            RD_REQ: begin
                if (w_ar_hs) w_next = RD_DATA;
            end
            RD_DATA: begin
                if (w_r_hs) w_next = RSP;
            end
            RSP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_live    <= 1'b0;
            r_write   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= '0;
            r_err     <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_cmd_hs) begin
                r_addr    <= cmd_addr;
                r_write   <= cmd_write;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (cmd_write) begin
                    r_wdata <= cmd_wdata;
                    r_wstrb <= cmd_wstrb;
                end
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_cap) begin
                r_resp  <= w_resp;
                r_rdata <= w_b_hs ? '0 : RDATA;
            end
            // saturate at all-ones rather than wrap
            if (w_cap && (w_resp != OKAY) && !(&r_err))
                r_err <= r_err + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomised bench for axi_lite_master with a memory-backed AXI-Lite slave.
// A scoreboard of expected responses is checked every cycle rsp_valid is high.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_ready;
    logic        cmd_ready, rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;
    logic [31:0] AWADDR, WDDATA, ARADDR, RDATA;
    logic [3:0]  WDSTRB;
    logic        AWVALID, WDVALID, BREADY, ARVALID, RREADY;
    logic        AWREADY, WDREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;

    logic        d2_cmd_ready, d2_rsp_valid, d2_rsp_write;
    logic [31:0] d2_rsp_rdata, d2_AWADDR, d2_WDDATA, d2_ARADDR;
    logic [1:0]  d2_rsp_resp, d2_err_count;
    logic [3:0]  d2_WDSTRB;
    logic        d2_AWVALID, d2_WDVALID, d2_BREADY, d2_ARVALID, d2_RREADY;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(16)) dut (
        .axi_clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .err_count(err_count),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDDATA(WDDATA), .WDSTRB(WDSTRB), .WDVALID(WDVALID),
        .WDREADY(WDREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
        .RREADY(RREADY)
    );

    // narrow counter copy shares every input to observe saturation
    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(2)) dut2 (
        .axi_clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(d2_rsp_write), .rsp_rdata(d2_rsp_rdata),
        .rsp_resp(d2_rsp_resp), .err_count(d2_err_count),
        .AWADDR(d2_AWADDR), .AWVALID(d2_AWVALID), .AWREADY(AWREADY),
        .WDDATA(d2_WDDATA), .WDSTRB(d2_WDSTRB), .WDVALID(d2_WDVALID),
        .WDREADY(WDREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(d2_BREADY),
        .ARADDR(d2_ARADDR), .ARVALID(d2_ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
        .RREADY(d2_RREADY)
    );

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          err;
    } exp_t;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    int          exp_err = 0;
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    int          dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
    logic [1:0]  resp_sel = OKAY;
    int          n_aw = 0, n_w = 0, n_ar = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
        input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    function automatic logic any_out();
        return |{cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                 err_count, AWADDR, AWVALID, WDDATA, WDSTRB, WDVALID,
                 BREADY, ARADDR, ARVALID, RREADY, d2_err_count,
                 d2_cmd_ready, d2_rsp_valid, d2_AWVALID};
    endfunction

    // slave: decides inputs at negedge; handshakes commit at the next posedge
    initial begin : slave
        logic        got_aw, got_w, got_ar;
        logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic        p_aw, p_w, p_ar;
        logic [31:0] s_awaddr, s_wdata, s_araddr, p_awaddr, p_wdata, p_araddr;
        logic [3:0]  s_wstrb, p_wstrb;
        int          aw_c, w_c, ar_c, b_c, r_c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                AWREADY = 0; WDREADY = 0; BVALID = 0; BRESP = 0;
                ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                p_aw = 0; p_w = 0; p_ar = 0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                continue;
            end
            if (aw_hs) begin got_aw = 1; n_aw++; end
            if (w_hs) begin got_w = 1; n_w++; end
            if (ar_hs) begin got_ar = 1; n_ar++; end
            if (b_hs) begin
                smem[s_awaddr] = merge(smem.exists(s_awaddr) ?
                    smem[s_awaddr] : 32'h0, s_wdata, s_wstrb);
                got_aw = 0; got_w = 0; BVALID = 0; b_c = 0;
            end
            if (r_hs) begin got_ar = 0; RVALID = 0; r_c = 0; end

            if (p_aw) check("awvalid_held", AWVALID, 1);
            if (p_aw) check("awaddr_stable", AWADDR, p_awaddr);
            if (p_w) check("wddata_stable", {WDSTRB, WDDATA},
                           {p_wstrb, p_wdata});
            if (p_ar) check("araddr_stable", {ARVALID, ARADDR},
                            {1'b1, p_araddr});
            if (AWVALID) check("aw_once", got_aw, 0);
            if (WDVALID) check("w_once", got_w, 0);
            if (ARVALID) check("ar_once", got_ar, 0);
            if (BREADY) check("bready_after_aw_w", got_aw && got_w, 1);
            if (RREADY) check("rready_after_ar", got_ar, 1);

            AWREADY = AWVALID && (aw_c >= dly_aw);
            if (AWVALID && !AWREADY) aw_c++;
            WDREADY = WDVALID && (w_c >= dly_w);
            if (WDVALID && !WDREADY) w_c++;
            ARREADY = ARVALID && (ar_c >= dly_ar);
            if (ARVALID && !ARREADY) ar_c++;
            if (got_aw && got_w && !BVALID) begin
                if (b_c >= dly_b) begin BVALID = 1; BRESP = resp_sel; end
                else b_c++;
            end
            if (got_ar && !RVALID) begin
                if (r_c >= dly_r) begin
                    RVALID = 1; RRESP = resp_sel;
                    RDATA = smem.exists(s_araddr) ? smem[s_araddr] : 32'h0;
                end else r_c++;
            end

            aw_hs = AWVALID && AWREADY;
            w_hs  = WDVALID && WDREADY;
            ar_hs = ARVALID && ARREADY;
            b_hs  = BVALID && BREADY;
            r_hs  = RVALID && RREADY;
            if (aw_hs) begin s_awaddr = AWADDR; aw_c = 0; end
            if (w_hs) begin s_wdata = WDDATA; s_wstrb = WDSTRB; w_c = 0; end
            if (ar_hs) begin s_araddr = ARADDR; ar_c = 0; end
            p_aw = AWVALID && !aw_hs; p_awaddr = AWADDR;
            p_w = WDVALID && !w_hs; p_wdata = WDDATA; p_wstrb = WDSTRB;
            p_ar = ARVALID && !ar_hs; p_araddr = ARADDR;
        end
    end

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("rsp_write", rsp_write, e.w);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("err_count", err_count, sat(e.err, 65535));
                    check("err_count_w2", d2_err_count, sat(e.err, 3));
                    check("busy_cmd_ready", cmd_ready, 0);
                    check("busy_axi_valid", {AWVALID, WDVALID, ARVALID}, 0);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_cmd(input logic w, input logic [31:0] a,
        input logic [31:0] d, input logic [3:0] s, input int hold,
        output int lat, output logic [31:0] rd, output logic [1:0] rs);
        int   n, aw0, w0, ar0;
        exp_t e;
        lat = 0; rd = 0; rs = 0; n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin check("cmd_ready_timeout", 0, 1); return; end
        aw0 = n_aw; w0 = n_w; ar0 = n_ar;
        cmd_valid = 1; cmd_write = w; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        e.w = w;
        e.rdata = (!w && mmem.exists(a)) ? mmem[a] : 32'h0;
        e.resp = resp_sel;
        if (resp_sel != OKAY) exp_err++;
        e.err = exp_err;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin check("rsp_timeout", 0, 1); return; end
        rd = rsp_rdata; rs = rsp_resp;
        repeat (hold) @(negedge clk);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_dropped", rsp_valid, 0);
        check("b2b_cmd_ready", cmd_ready, 1);
        check("aw_hs_count", n_aw - aw0, w);
        check("w_hs_count", n_w - w0, w);
        check("ar_hs_count", n_ar - ar0, !w);
        if (w) mmem[a] = merge(mmem.exists(a) ? mmem[a] : 32'h0, d, s);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin : main
        int          lat, n;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        w;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", any_out(), 0);
        rst_n = 1;
        #1 check("cmd_ready_pre_edge", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);

        do_cmd(1, 32'h4, 32'd10, 4'hF, 0, lat, rd, rs);
        check("wr_latency", lat, 3);
        check("wr_resp_okay", rs, OKAY);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, lat, rd, rs);
        check("rd_latency", lat, 3);
        check("rd_data_10", rd, 32'd10);
        check("rd_resp_okay", rs, OKAY);

        dly_aw = 4;
        do_cmd(1, 32'h8, 32'h55, 4'h1, 0, lat, rd, rs);
        check("skew_aw_latency", lat, 7);
        dly_aw = 0; dly_w = 4;
        do_cmd(1, 32'h8, 32'hAA00, 4'h2, 0, lat, rd, rs);
        check("skew_w_latency", lat, 7);
        dly_w = 0;
        do_cmd(0, 32'h8, 32'h0, 4'h0, 0, lat, rd, rs);
        check("skew_rd_data", rd, 32'hAA55);

        resp_sel = SLVERR;
        do_cmd(1, 32'hC, 32'h1234, 4'hF, 0, lat, rd, rs);
        check("slverr_resp", rs, SLVERR);
        resp_sel = DECERR;
        do_cmd(0, 32'hC, 32'h0, 4'h0, 0, lat, rd, rs);
        check("decerr_resp", rs, DECERR);
        check("err_count_2", err_count, 2);
        resp_sel = SLVERR;
        do_cmd(1, 32'h10, 32'h1, 4'hF, 0, lat, rd, rs);
        do_cmd(1, 32'h10, 32'h2, 4'hF, 0, lat, rd, rs);
        check("err_count_4", err_count, 4);
        check("err_count_w2_sat", d2_err_count, 3);
        resp_sel = OKAY;

        do_cmd(0, 32'h4, 32'h0, 4'h0, 10, lat, rd, rs);
        check("backpressure_rdata", rd, 32'd10);

        for (int i = 0; i < 150; i++) begin
            dly_aw = $urandom_range(0, 3); dly_w = $urandom_range(0, 3);
            dly_b = $urandom_range(0, 3); dly_ar = $urandom_range(0, 3);
            dly_r = $urandom_range(0, 3);
            resp_sel = ($urandom_range(0, 3) == 0) ?
                       2'($urandom_range(0, 3)) : OKAY;
            w = 1'($urandom_range(0, 1));
            do_cmd(w, {27'h0, 3'($urandom_range(0, 7)), 2'b00},
                   $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), lat, rd, rs);
        end
        dly_w = 0; dly_b = 0; dly_ar = 0; dly_r = 0; resp_sel = OKAY;

        dly_aw = 50;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!AWVALID && n < 20) begin @(negedge clk); n++; end
        check("midrst_awvalid_seen", AWVALID, 1);
        #3 rst_n = 0;
        #1 check("midrst_outputs_zero", any_out(), 0);
        exp_q.delete();
        exp_err = 0;
        dly_aw = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        do_cmd(0, 32'h8, 32'h0, 4'h0, 0, lat, rd, rs);
        check("post_rst_rd_latency", lat, 3);
        check("post_rst_resp", rs, OKAY);
        check("post_rst_err_count", err_count, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Synthesizable AXI4-Lite initiator that turns a simple one-at-a-time command/response interface into AXI4-Lite write and read transactions. It is the RTL counterpart of the peripheral-side slaves, such as the timer, and lets on-chip logic program and poll those register blocks without a testbench. Only one transaction is outstanding at a time. Results are returned on a response port, and a saturating counter tracks error responses.

## Interface
- ADDR_W, 32: AXI and command address width
- DATA_W, 32: data width; strobe width is DATA_W/8
- ERR_CNT_W, 16: width of the error counter
- axi_clk  in  1  sole clock; all logic is on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target byte address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_W  RDATA for reads; 0 for writes
- rsp_resp  out  2  captured BRESP or RRESP
- err_count  out  ERR_CNT_W  saturating count of non-OKAY responses
- AWADDR out ADDR_W, AWVALID out 1, AWREADY in 1: write address channel
- WDDATA out DATA_W, WDSTRB out DATA_W/8, WDVALID out 1, WDREADY in 1: write data channel
- BRESP in 2, BVALID in 1, BREADY out 1: write response channel
- ARADDR out ADDR_W, ARVALID out 1, ARREADY in 1: read address channel
- RDATA in DATA_W, RRESP in 2, RVALID in 1, RREADY out 1: read data channel

## Operation
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- **IDLE:** cmd_ready=1.
  - On accepting a write command: latch addr, wdata and wstrb, then go to WR_REQ.
  - On accepting a read command: latch addr, then go to RD_REQ.
- **WR_REQ:**
  - AWVALID and WDVALID rise together on entry.
  - Each valid drops independently in the cycle after its own handshake (VALID & READY at an edge).
  - aw_done and w_done flags record completion.
  - When both are done, go to WR_RESP. This covers either order, and also both completing in the same cycle.
- **WR_RESP:**
  - BREADY=1.
  - On BVALID & BREADY: capture BRESP into rsp_resp, set rsp_rdata=0, go to RSP.
- **RD_REQ:** ARVALID=1 until the AR handshake, then go to RD_DATA.
- **RD_DATA:**
  - RREADY=1.
  - On RVALID & RREADY: capture RDATA and RRESP, go to RSP.
- **RSP:**
  - rsp_valid=1, with all rsp_* outputs held stable.
  - On rsp_ready: go to IDLE.
- **Valid rules:** a VALID never depends on its READY. AWADDR, WDDATA, WDSTRB and ARADDR are held stable from VALID rise until the handshake.
- **err_count:** increments by 1 on each captured response with resp ≠ OKAY. It saturates at all-ones and never wraps.
- A command presented while the block is not in IDLE waits, because cmd_ready=0.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, and err_count is 0. cmd_ready becomes 1 in the first cycle after reset is released.
- **Reset mid-transaction:** abort immediately and drop every VALID, READY and rsp_valid. The attached slaves share rst_n.
- **Zero-wait slave, write:**
  - Accept at edge T0.
  - AW and W handshake at T1.
  - B handshake at T2 at the earliest, since BREADY first rises after T1.
  - rsp_valid is high after T2.
- **Zero-wait slave, read:** accept at T0, AR handshake at T1, R handshake at T2, rsp_valid after T2.
- **Back-to-back:** with rsp_ready held high, the next command is accepted one cycle after the response handshake.
- BREADY and RREADY are asserted only in their wait states. Stray BVALID or RVALID outside those states is ignored.

## Structure
- **Package axi_lite_pkg:**
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Master state_t enum.
  - Timer register address constants: CONTROL=0x0, PRESCALER=0x4, COUNTER=0x8.
- Single module, with no sub-module. The error counter and channel flags are inline.

## Test plan
- **Write then read with a zero-wait slave model:** write 10 to 0x4, then read 0x4 → rsp_rdata=10, rsp_resp=OKAY. Write latency is exactly 3 edges to rsp_valid.
- **AW/W skew:** AWREADY delayed 4 cycles while WDREADY is immediate, then the reverse → exactly one AW handshake and one W handshake each. WR_RESP is entered only after both.
- **Error response:** slave returns SLVERR on a write, then DECERR on a read → rsp_resp matches each time and err_count=2. Forcing saturation with ERR_CNT_W=2 holds err_count at 3.
- **Response backpressure:** rsp_ready held low for 10 cycles → rsp_* stable, cmd_ready=0, and no new AXI valid asserted.
- **Mid-transaction reset:** rst_n asserted while AWVALID=1 with AWREADY=0 → all outputs 0 asynchronously. After release, a read of 0x8 completes normally.
- **Timer integration:** connect to axi_timer_top; write 10 to 0x4 and 1 to 0x0, wait 60 cycles, read 0x8 → 5. Write 2 to 0x0, then read 0x8 → 0.
